// File: rtl/mac_requant_axis_pkg.sv
// Shared definitions for the MAC requantization stage: saturation limits and
// the round-half-up / saturate helper, evaluated at 64 bits so one function
// serves every parameterization.
package mac_requant_axis_pkg;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } rq_t;

  // Largest value representable in a w-bit two's complement word.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Drop s fractional bits with round-half-up, then clamp to a w-bit range.
  // The 64-bit working width leaves ample headroom for the rounding add.
  function automatic rq_t requant(input logic signed [63:0] x, input int s, input int w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rq_t                o;
    if (s > 0) r = (x + (64'sd1 <<< (s - 1))) >>> s;
    else       r = x;
    hi = sat_hi(w);
    lo = sat_lo(w);
    o.sat = 1'b0;
    o.value = r;
    if (r > hi) begin
      o.value = hi;
      o.sat   = 1'b1;
    end else if (r < lo) begin
      o.value = lo;
      o.sat   = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rd_data whenever count is non-zero; rd_data reads as zero when empty.
// The caller guarantees rd_en only when non-empty and wr_en only when not
// full or popping in the same cycle.
module mac_result_fifo
  import mac_requant_axis_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer advance (natural modulo-DEPTH wrap) and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count so it needs no reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/mac_requant_axis.sv
// Requantizes MAC accumulator results to a narrower fixed-point format,
// registers them once, and buffers them in a FWFT FIFO behind a
// ready/valid master port. Beats that find the FIFO full are dropped.
module mac_requant_axis
  import mac_requant_axis_pkg::*;
#(
  parameter int IN_INT   = 12,
  parameter int IN_FRAC  = 16,
  parameter int OUT_INT  = 6,
  parameter int OUT_FRAC = 8,
  parameter int DEPTH    = 4
) (
  input  logic                                clock,
  input  logic                                rstn,
  input  logic signed [IN_INT+IN_FRAC-1:0]    in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic signed [OUT_INT+OUT_FRAC-1:0]  m_data,
  output logic                                m_sat,
  output logic                                m_last,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                drop_sticky,
  input  logic                                clr_drop
);

  localparam int OUT_W = OUT_INT + OUT_FRAC;
  localparam int S     = IN_FRAC - OUT_FRAC;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FW    = OUT_W + 2;

  rq_t                rq;
  logic               unused_rq_hi;
  logic [OUT_W-1:0]   data_p1_q, data_p1_d;
  logic               sat_p1_q, sat_p1_d;
  logic               last_p1_q, last_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic               drop_sticky_q, drop_sticky_d;
  logic [FW-1:0]      head;
  logic [CW-1:0]      fifo_count;
  logic               full, pop, push, drop;

  // Round and saturate the incoming result; capture it into stage 1 on valid.
  always_comb begin
    rq           = requant(64'(in_data), S, OUT_W);
    unused_rq_hi = ^rq.value[63:OUT_W];
    data_p1_d    = data_p1_q;
    sat_p1_d     = sat_p1_q;
    last_p1_d    = last_p1_q;
    vld_p1_d     = in_valid;
    if (in_valid) begin
      data_p1_d = rq.value[OUT_W-1:0];
      sat_p1_d  = rq.sat;
      last_p1_d = in_last;
    end
  end

  // ---- stage p1: requantized beat ----
  // Stage-1 payload; qualified by vld_p1_q so it carries no reset.
  always_ff @(posedge clock) begin
    data_p1_q <= data_p1_d;
    sat_p1_q  <= sat_p1_d;
    last_p1_q <= last_p1_d;
  end

  // Stage-1 valid flag and drop indicator.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q      <= 1'b0;
      drop_sticky_q <= 1'b0;
    end else begin
      vld_p1_q      <= vld_p1_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

  // Push/pop arbitration; a full FIFO still accepts a beat when it pops.
  always_comb begin
    full          = (fifo_count == CW'(DEPTH));
    pop           = m_valid && m_ready;
    push          = vld_p1_q && (!full || pop);
    drop          = vld_p1_q && full && !pop;
    drop_sticky_d = drop_sticky_q;
    if (drop)          drop_sticky_d = 1'b1;
    else if (clr_drop) drop_sticky_d = 1'b0;
  end

  // ---- stage fifo: buffered output ----
  mac_result_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rstn    (rstn),
    .wr_en   (push),
    .wr_data ({sat_p1_q, last_p1_q, data_p1_q}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign m_sat       = head[FW-1];
  assign m_last      = head[FW-2];
  assign m_data      = head[OUT_W-1:0];
  assign m_valid     = (fifo_count != '0);
  assign count       = fifo_count;
  assign drop_sticky = drop_sticky_q;

endmodule

// File: tb/tb_mac_requant_axis.sv
// Self-checking bench for mac_requant_axis with a queue-based reference model.
module tb_mac_requant_axis;

  localparam int IN_INT = 12, IN_FRAC = 16, OUT_INT = 6, OUT_FRAC = 8, DEPTH = 4;
  localparam int IN_W = IN_INT + IN_FRAC;
  localparam int OUT_W = OUT_INT + OUT_FRAC;
  localparam int S = IN_FRAC - OUT_FRAC;

  logic                   clock = 1'b0;
  logic                   rstn;
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid, in_last;
  logic [OUT_W-1:0]       m_data;
  logic                   m_sat, m_last, m_valid, m_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   drop_sticky, clr_drop;

  mac_requant_axis #(
    .IN_INT(IN_INT), .IN_FRAC(IN_FRAC), .OUT_INT(OUT_INT), .OUT_FRAC(OUT_FRAC), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .m_data(m_data), .m_sat(m_sat), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .drop_sticky(drop_sticky), .clr_drop(clr_drop)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             sat;
    logic             last;
  } beat_t;

  beat_t mq[$];
  beat_t s1_b;
  bit    s1_v;
  bit    m_sticky;
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Real-number view of the conversion: floor((x + half LSB) / 2^S), then clamp.
  function automatic beat_t ref_rq(input longint x, input logic l);
    longint v, r, hi, lo, m;
    beat_t  b;
    m  = longint'(1) << S;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -hi - 1;
    v  = x + m / 2;
    r  = (v - (((v % m) + m) % m)) / m;
    b.sat = 1'b0;
    if (r > hi) begin r = hi; b.sat = 1'b1; end
    if (r < lo) begin r = lo; b.sat = 1'b1; end
    b.d    = r[OUT_W-1:0];
    b.last = l;
    return b;
  endfunction

  // Reference model: one-beat input register feeding a bounded queue.
  always @(posedge clock or negedge rstn) begin
    int sz;
    bit pop, drop;
    if (!rstn) begin
      mq.delete();
      s1_v     = 1'b0;
      m_sticky = 1'b0;
    end else begin
      sz   = mq.size();
      pop  = (sz > 0) && m_ready;
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (s1_v) begin
        if (sz < DEPTH || pop) mq.push_back(s1_b);
        else drop = 1'b1;
      end
      if (drop) m_sticky = 1'b1;
      else if (clr_drop) m_sticky = 1'b0;
      s1_v = in_valid;
      s1_b = ref_rq(longint'(in_data), in_last);
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clock) begin
    if (!rstn) begin
      check("rst_count", 64'(count), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_m_sat", 64'(m_sat), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_drop_sticky", 64'(drop_sticky), 64'd0);
    end else begin
      check("count", 64'(count), 64'(mq.size()));
      check("m_valid", 64'(m_valid), 64'(mq.size() != 0));
      check("drop_sticky", 64'(drop_sticky), 64'(m_sticky));
      if (mq.size() > 0) begin
        check("m_data", 64'(m_data), 64'(mq[0].d));
        check("m_sat", 64'(m_sat), 64'(mq[0].sat));
        check("m_last", 64'(m_last), 64'(mq[0].last));
      end
    end
  end

  task automatic one_beat(input string name, input logic signed [IN_W-1:0] x,
                          input logic [OUT_W-1:0] exp_d, input logic exp_s);
    m_ready = 1'b1;
    @(posedge clock); #1;
    in_data = x; in_valid = 1'b1; in_last = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check({name, "_latency"}, 64'(m_valid), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check({name, "_valid"}, 64'(m_valid), 64'd1);
    check({name, "_data"}, 64'(m_data), 64'(exp_d));
    check({name, "_sat"}, 64'(m_sat), 64'(exp_s));
  endtask

  initial begin
    beat_t b;
    int    r;
    rstn = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    m_ready = 1'b0; clr_drop = 1'b0;
    repeat (3) @(posedge clock);
    #1 rstn = 1'b1;

    // Hand-computed pins on the reference model itself.
    b = ref_rq(longint'('h18000), 1'b0);   check("model_p1p5", 64'(b.d), 64'h0180);
    b = ref_rq(-longint'('h18000), 1'b0);  check("model_m1p5", 64'(b.d), 64'h3E80);
    b = ref_rq(longint'('h80), 1'b0);      check("model_half", 64'(b.d), 64'h0001);
    b = ref_rq(-longint'('h80), 1'b0);     check("model_mhalf", 64'(b.d), 64'h0000);
    b = ref_rq(longint'('h280000), 1'b0);  check("model_satp", 64'({b.sat, b.d}), 64'h5FFF);
    b = ref_rq(-longint'('h280000), 1'b0); check("model_satn", 64'({b.sat, b.d}), 64'h6000);

    // Directed conversions with literal expectations.
    one_beat("pos1p5", 28'sh0018000, 14'h0180, 1'b0);
    one_beat("neg1p5", -28'sh0018000, 14'h3E80, 1'b0);
    one_beat("rnd_half", 28'sh0000080, 14'h0001, 1'b0);
    one_beat("rnd_mhalf", -28'sh0000080, 14'h0000, 1'b0);
    one_beat("rnd_7f", 28'sh000007F, 14'h0000, 1'b0);
    one_beat("sat_pos", 28'sh0280000, 14'h1FFF, 1'b1);
    one_beat("sat_neg", -28'sh0280000, 14'h2000, 1'b1);

    // Backpressure with overflow: six beats into a four-entry FIFO.
    @(posedge clock); #1 m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      in_data = IN_W'(k * 256); in_valid = 1'b1; in_last = (k == 6);
    end
    @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("bp_count", 64'(count), 64'd4);
    check("bp_drop", 64'(drop_sticky), 64'd1);
    @(posedge clock); #1 m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("bp_order", 64'(m_data), 64'(i));
      check("bp_last", 64'(m_last), 64'd0);
      @(posedge clock);
    end
    @(negedge clock);
    check("bp_drained", 64'(count), 64'd0);
    @(posedge clock); #1 clr_drop = 1'b1;
    @(posedge clock); #1 clr_drop = 1'b0;
    @(negedge clock);
    check("bp_clr", 64'(drop_sticky), 64'd0);

    // Full FIFO with simultaneous push and pop every cycle.
    for (int k = 0; k < 25; k++) begin
      @(posedge clock); #1;
      in_data = IN_W'((k + 10) * 256); in_valid = 1'b1; in_last = (k % 7 == 6);
      m_ready = (k >= 5);
      if (k >= 8) check("full_pp_count", 64'(count), 64'd4);
    end
    @(posedge clock); #1 in_valid = 1'b0; in_last = 1'b0;
    check("full_pp_nodrop", 64'(drop_sticky), 64'd0);
    repeat (8) @(posedge clock);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      @(posedge clock); #1;
      r = int'($urandom_range(0, 1023)) - 512;
      case ($urandom_range(0, 3))
        0:       in_data = IN_W'($urandom);
        1:       in_data = IN_W'(r);
        2:       in_data = IN_W'(8191 * 256 + r);
        default: in_data = IN_W'(-8192 * 256 + r);
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 4) == 0);
      m_ready  = (c % 100 < 30) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      clr_drop = ($urandom_range(0, 19) == 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; clr_drop = 1'b0; m_ready = 1'b1;
    repeat (8) @(posedge clock);

    // Reset mid-stream: three beats buffered and one in the input register.
    #1 m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      in_data = IN_W'((k + 1) * 256); in_valid = 1'b1; in_last = 1'b0;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("mid_buffered", 64'(count), 64'd3);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("mid_no_stale", 64'(m_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_requant_axis.md
# mac_requant_axis

Downstream stage of the fixed-point MAC. It takes each accumulated result (full-precision Q(IN_INT).(IN_FRAC), one-cycle valid/last pulses, no backpressure) and rounds and saturates it to Q(OUT_INT).(OUT_FRAC). The results are buffered in a small FIFO and presented on an AXI-Stream-style master port with ready backpressure. Beats that arrive while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- IN_INT, 12, integer bits of the input (MAC accumulator)
- IN_FRAC, 16, fractional bits of the input
- OUT_INT, 6, integer bits of the output; must satisfy OUT_INT <= IN_INT
- OUT_FRAC, 8, fractional bits of the output; must satisfy OUT_FRAC <= IN_FRAC
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clock, in, 1, clock; all logic is rising-edge
- rstn, in, 1, reset: asynchronous, active-low
- in_data, in, IN_INT+IN_FRAC, signed accumulated result
- in_valid, in, 1, in_data is valid this cycle; there is no ready
- in_last, in, 1, marks the final result of a frame
- m_data, out, OUT_INT+OUT_FRAC, signed requantized result
- m_sat, out, 1, this beat was saturated
- m_last, out, 1, in_last carried through with the beat
- m_valid, out, 1, master valid
- m_ready, in, 1, downstream ready
- count, out, $clog2(DEPTH)+1, FIFO occupancy
- drop_sticky, out, 1, at least one beat was dropped since reset or clear
- clr_drop, in, 1, synchronous clear of drop_sticky

## Operation
- Shift amount is S = IN_FRAC − OUT_FRAC.
- Rounding is round-half-up (toward +inf):
  - If S > 0: r = (in_data + 2^(S−1)) >>> S, computed at IN width + 1 bit, so it cannot wrap.
  - If S = 0: r = in_data.
- Saturation:
  - Range is [−2^(W−1), 2^(W−1)−1], where W = OUT_INT+OUT_FRAC.
  - An out-of-range r clamps to the nearest limit, and m_sat = 1 for that beat.
- Stage 1 register {data, sat, last, vld} captures the result when in_valid = 1, and otherwise loads vld = 0. It never stalls.
- FIFO:
  - Write when stage-1 vld = 1 and (not full, or pop in the same cycle).
  - Pop when m_valid && m_ready.
  - First-word-fall-through: the head entry drives m_data, m_sat and m_last. m_valid = (count != 0).
  - Simultaneous push and pop leaves count unchanged. This is legal at full and at empty+1.
  - Read and write pointers wrap modulo DEPTH.
- Drop: when stage-1 vld = 1, the FIFO is full and there is no pop, the beat is discarded and drop_sticky is set.
- drop_sticky:
  - Set has priority over clr_drop in the same cycle.
  - Otherwise clr_drop = 1 clears it on the next edge.
- m_data, m_sat and m_last stay stable while m_valid && !m_ready.

## Timing
- Reset (asynchronous assert, synchronous release):
  - count = 0, m_valid = 0, m_data = 0, m_sat = 0, m_last = 0, drop_sticky = 0.
  - Stage-1 vld = 0 and both pointers = 0.
- Latency: in_valid sampled at edge N gives m_valid = 1 after edge N+1, provided the FIFO was empty.
- Throughput: one beat per cycle when m_ready is held at 1.
- Reset mid-operation: all buffered and in-flight beats are lost. No partial beat appears after rstn deasserts.
- FIFO state machine: the occupancy counter is the only state. Transitions are EMPTY → PARTIAL → FULL and back, with no extra FSM.

## Structure
- A shared package holds:
  - a localparam function for the saturation limits;
  - the requant rounding/saturate function (pure, parameter-width).
- One sub-module is natural: mac_result_fifo.
  - It is a parameterized FWFT synchronous FIFO carrying {sat, last, data}, with a count output.
- The top level contains the rounding/saturation logic, stage 1, drop logic and the sticky flag.

## Test plan
- Nominal conversion, default parameters:
  - in_data = 0x18000 (1.5) → m_data = 0x0180, m_sat = 0.
  - in_data = −0x18000 → m_data = 0x3E80 (−1.5 in 14 bits).
- Rounding:
  - 0x00080 (+0.5 LSB) → 0x0001.
  - −0x80 (−0.5 LSB) → 0x0000.
  - 0x0007F → 0x0000.
- Saturation:
  - 40.0 (0x280000) → 0x1FFF, m_sat = 1.
  - −40.0 → 0x2000, m_sat = 1.
- Backpressure and drop: m_ready = 0 and 6 consecutive beats (values 1..6, last on beat 6).
  - Expect count = 4 and drop_sticky = 1.
  - Then m_ready = 1: expect beats 1..4 in order with m_last = 0, then count = 0.
  - clr_drop pulse → drop_sticky = 0.
- Full with simultaneous push/pop: FIFO full, m_ready = 1 and continuous in_valid.
  - Expect no drop, count stays at 4, and output order is preserved.
- Reset mid-stream: assert rstn = 0 with 3 beats buffered and 1 in stage 1.
  - Immediately: m_valid = 0, count = 0.
  - After release: no stale beats are emitted.
